// File: rtl/rv_csr_file.sv
// Machine-mode CSR unit: registers a CSR request, then performs the read-modify-write
// one cycle later; holds trap CSRs, a scratch bank and the cycle/instret counters.
module rv_csr_file #(
  parameter int NUM_SCRATCH = 4,
  parameter int CNT_WIDTH   = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [11:0] i_idx,
  input  logic [1:0]  i_op,
  input  logic        i_sel,
  input  logic [4:0]  i_imm,
  input  logic [31:0] i_data,
  input  logic        i_retire,
  input  logic        i_trap,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_cause,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_illegal,
  output logic [31:0] o_mtvec
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  function automatic logic [31:0] csr_wval(input logic [1:0] op, input logic [31:0] old,
                                           input logic [31:0] opnd);
    case (op)
      OP_RW:   csr_wval = opnd;
      OP_RS:   csr_wval = old | opnd;
      OP_RC:   csr_wval = old & ~opnd;
      default: csr_wval = old;
    endcase
  endfunction

  // A write to either half replaces only that half and holds off the increment.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic we_lo, input logic we_hi,
                                                    input logic inc, input logic [31:0] wval);
    cnt_next = cur;
    if (we_lo)
      cnt_next[31:0] = wval;
    else if (we_hi)
      cnt_next[CNT_WIDTH-1:32] = wval[CNT_WIDTH-33:0];
    else if (inc)
      cnt_next = cur + CNT_WIDTH'(1);
  endfunction

  // ---- stage p0 -> p1: request capture
  logic        vld_p1;
  logic [11:0] idx_p1;
  logic [1:0]  op_p1;
  logic        sel_p1;
  logic [4:0]  imm_p1;
  logic [31:0] data_p1;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    idx_p1  <= i_idx;
    op_p1   <= i_op;
    sel_p1  <= i_sel;
    imm_p1  <= i_imm;
    data_p1 <= i_data;
  end

  // ---- stage p1: read, decode and write-back
  logic [31:0]          mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0]          scratch_q [16];
  logic [CNT_WIDTH-1:0] mcycle_q, minstret_q;
  logic [63:0]          cyc64, ins64;

  logic [31:0] operand_p1, old_p1, wval_p1;
  logic        mapped_p1, wr_req_p1, illegal_p1, wr_en_p1;

  always_comb begin
    cyc64 = '0;
    ins64 = '0;
    cyc64[CNT_WIDTH-1:0] = mcycle_q;
    ins64[CNT_WIDTH-1:0] = minstret_q;
  end

  always_comb begin
    operand_p1 = sel_p1 ? {27'd0, imm_p1} : data_p1;
    old_p1     = '0;
    mapped_p1  = 1'b1;
    case (idx_p1)
      12'h305:          old_p1 = mtvec_q;
      12'h340:          old_p1 = mscratch_q;
      12'h341:          old_p1 = mepc_q;
      12'h342:          old_p1 = mcause_q;
      12'hB00, 12'hC00: old_p1 = cyc64[31:0];
      12'hB80, 12'hC80: old_p1 = cyc64[63:32];
      12'hB02, 12'hC02: old_p1 = ins64[31:0];
      12'hB82, 12'hC82: old_p1 = ins64[63:32];
      default: begin
        if (idx_p1[11:4] == 8'h7C && {1'b0, idx_p1[3:0]} < 5'(NUM_SCRATCH))
          old_p1 = scratch_q[idx_p1[3:0]];
        else
          mapped_p1 = 1'b0;
      end
    endcase
    // Set/clear with a zero operand is a pure read, so it is legal on read-only CSRs.
    wr_req_p1  = (op_p1 == OP_RW) ||
                 ((op_p1 == OP_RS || op_p1 == OP_RC) && operand_p1 != 32'd0);
    illegal_p1 = vld_p1 && (!mapped_p1 || (idx_p1[11:10] == 2'b11 && wr_req_p1));
    wr_en_p1   = vld_p1 && !i_reset && wr_req_p1 && !illegal_p1;
    wval_p1    = csr_wval(op_p1, old_p1, operand_p1);
  end

  logic we_mtvec, we_mscratch, we_mepc, we_mcause;
  logic we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;

  always_comb begin
    we_mtvec    = wr_en_p1 && idx_p1 == 12'h305;
    we_mscratch = wr_en_p1 && idx_p1 == 12'h340;
    we_mepc     = wr_en_p1 && idx_p1 == 12'h341;
    we_mcause   = wr_en_p1 && idx_p1 == 12'h342;
    we_cyc_lo   = wr_en_p1 && idx_p1 == 12'hB00;
    we_cyc_hi   = wr_en_p1 && idx_p1 == 12'hB80;
    we_ins_lo   = wr_en_p1 && idx_p1 == 12'hB02;
    we_ins_hi   = wr_en_p1 && idx_p1 == 12'hB82;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      for (int k = 0; k < 16; k++)
        scratch_q[k] <= '0;
    end else begin
      if (we_mtvec)
        mtvec_q <= {wval_p1[31:2], 2'b00};
      if (we_mscratch)
        mscratch_q <= wval_p1;
      if (i_trap) begin
        mepc_q   <= i_trap_pc & ~32'd1;
        mcause_q <= i_trap_cause;
      end else begin
        if (we_mepc)
          mepc_q <= {wval_p1[31:1], 1'b0};
        if (we_mcause)
          mcause_q <= wval_p1;
      end
      for (int k = 0; k < 16; k++)
        if (k < NUM_SCRATCH && wr_en_p1 && idx_p1 == 12'h7C0 + 12'(k))
          scratch_q[k] <= wval_p1;
      mcycle_q   <= cnt_next(mcycle_q, we_cyc_lo, we_cyc_hi, 1'b1, wval_p1);
      minstret_q <= cnt_next(minstret_q, we_ins_lo, we_ins_hi, i_retire, wval_p1);
    end
  end

  assign o_valid   = vld_p1 && !i_reset;
  assign o_illegal = o_valid && illegal_p1;
  assign o_data    = (o_valid && !illegal_p1) ? old_p1 : 32'd0;
  assign o_mtvec   = {mtvec_q[31:2], 2'b00};

endmodule

// File: tb/tb_rv_csr_file.sv
// Directed bench for rv_csr_file: hand-computed expectations for reads, RMW ops,
// counters, illegal accesses, trap priority, flush and reset.
module tb_rv_csr_file;

  logic        i_clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_sel, i_retire, i_trap;
  logic [11:0] i_idx;
  logic [1:0]  i_op;
  logic [4:0]  i_imm;
  logic [31:0] i_data, i_trap_pc, i_trap_cause;
  logic [31:0] o_data, o_mtvec;
  logic        o_valid, o_illegal;

  int n_checks = 0;
  int n_errors = 0;

  rv_csr_file #(.NUM_SCRATCH(4), .CNT_WIDTH(64)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_idx(i_idx), .i_op(i_op), .i_sel(i_sel), .i_imm(i_imm), .i_data(i_data),
    .i_retire(i_retire), .i_trap(i_trap), .i_trap_pc(i_trap_pc),
    .i_trap_cause(i_trap_cause), .o_data(o_data), .o_valid(o_valid),
    .o_illegal(o_illegal), .o_mtvec(o_mtvec)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Presents one request for a cycle; on return its response is on the outputs.
  task automatic csr(input logic [1:0] op, input logic [11:0] idx, input logic sel,
                     input logic [4:0] imm, input logic [31:0] data);
    i_valid = 1'b1; i_op = op; i_idx = idx; i_sel = sel; i_imm = imm; i_data = data;
    tick();
    i_valid = 1'b0; i_op = 2'b00; i_sel = 1'b0; i_imm = '0; i_data = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] idx, input logic [31:0] exp);
    csr(2'b00, idx, 1'b0, 5'd0, 32'd0);
    chk({tag, "_vld"}, 32'(o_valid), 32'd1);
    chk(tag, o_data, exp);
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_sel = 1'b0; i_retire = 1'b0;
    i_trap = 1'b0; i_idx = '0; i_op = '0; i_imm = '0; i_data = '0;
    i_trap_pc = '0; i_trap_cause = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk("rst_mtvec", o_mtvec, 32'd0);

    // mcycle is 0 in the release cycle, so a read issued then sees 1, the next 2
    i_reset = 1'b0;
    rd("mcycle_first", 12'hB00, 32'd1);
    rd("mcycle_second", 12'hB00, 32'd2);

    csr(2'b01, 12'h340, 1'b0, 5'd0, 32'hDEADBEEF);
    chk("mscr_rw_old", o_data, 32'd0);
    csr(2'b10, 12'h340, 1'b1, 5'd5, 32'd0);
    chk("mscr_rs_old", o_data, 32'hDEADBEEF);
    rd("mscr_final", 12'h340, 32'hDEADBEEF);

    csr(2'b01, 12'h305, 1'b0, 5'd0, 32'h12345677);
    chk("mtvec_old", o_data, 32'd0);
    rd("mtvec_rd", 12'h305, 32'h12345674);
    chk("mtvec_out", o_mtvec, 32'h12345674);

    // Low write, high write (no increment on either commit), then two free-running cycles
    csr(2'b01, 12'hB00, 1'b0, 5'd0, 32'hFFFFFFFE);
    csr(2'b01, 12'hB80, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    rd("carry_lo", 12'hB00, 32'd0);
    rd("carry_hi", 12'hB80, 32'd1);
    rd("minstret_idle", 12'hB02, 32'd0);
    rd("minstreth_idle", 12'hB82, 32'd0);

    i_retire = 1'b1;
    repeat (3) tick();
    i_retire = 1'b0;
    rd("minstret_3", 12'hB02, 32'd3);

    csr(2'b01, 12'hB02, 1'b0, 5'd0, 32'h10);
    i_retire = 1'b1;
    tick();
    tick();
    i_retire = 1'b0;
    rd("minstret_wr_inc", 12'hB02, 32'h11);

    csr(2'b01, 12'hB00, 1'b0, 5'd0, 32'h100);
    csr(2'b01, 12'hC00, 1'b0, 5'd0, 32'd5);
    chk("ro_rw_illegal", 32'(o_illegal), 32'd1);
    chk("ro_rw_data", o_data, 32'd0);
    chk("ro_rw_valid", 32'(o_valid), 32'd1);
    csr(2'b10, 12'hC00, 1'b1, 5'd0, 32'd0);
    chk("ro_rs0_illegal", 32'(o_illegal), 32'd0);
    chk("ro_rs0_data", o_data, 32'h101);

    csr(2'b00, 12'h7C4, 1'b0, 5'd0, 32'd0);
    chk("scr_oob_illegal", 32'(o_illegal), 32'd1);
    chk("scr_oob_data", o_data, 32'd0);
    csr(2'b01, 12'h7C3, 1'b0, 5'd0, 32'hA5A5);
    chk("scr3_old", o_data, 32'd0);
    chk("scr3_legal", 32'(o_illegal), 32'd0);
    csr(2'b11, 12'h7C3, 1'b0, 5'd0, 32'h00FF);
    chk("scr3_rc_old", o_data, 32'hA5A5);
    rd("scr3_rc", 12'h7C3, 32'hA500);
    csr(2'b00, 12'h123, 1'b0, 5'd0, 32'd0);
    chk("unmapped_illegal", 32'(o_illegal), 32'd1);

    csr(2'b01, 12'h341, 1'b0, 5'd0, 32'h55);
    rd("mepc_bit0", 12'h341, 32'h54);

    csr(2'b01, 12'h341, 1'b0, 5'd0, 32'h55);
    i_trap = 1'b1; i_trap_pc = 32'h80000103; i_trap_cause = 32'hB;
    tick();
    i_trap = 1'b0;
    rd("trap_mepc", 12'h341, 32'h80000102);
    rd("trap_mcause", 12'h342, 32'hB);

    csr(2'b01, 12'h340, 1'b0, 5'd0, 32'h77);
    i_trap = 1'b1; i_trap_pc = 32'h200; i_trap_cause = 32'h3;
    tick();
    i_trap = 1'b0;
    rd("trap_other_wr", 12'h340, 32'h77);
    rd("trap2_mepc", 12'h341, 32'h200);
    rd("trap2_mcause", 12'h342, 32'h3);

    i_flush = 1'b1;
    csr(2'b01, 12'h340, 1'b0, 5'd0, 32'h1234);
    i_flush = 1'b0;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_data", o_data, 32'd0);
    rd("flush_nowrite", 12'h340, 32'h77);

    csr(2'b01, 12'h340, 1'b0, 5'd0, 32'h9999);
    i_reset = 1'b1;
    #1;
    chk("rst_inflight_valid", 32'(o_valid), 32'd0);
    tick();
    tick();
    i_reset = 1'b0;
    rd("post_rst_mcycle", 12'hB00, 32'd1);
    rd("post_rst_mscratch", 12'h340, 32'd0);
    rd("post_rst_mtvec", 12'h305, 32'd0);
    chk("post_rst_mtvec_out", o_mtvec, 32'd0);
    rd("post_rst_mepc", 12'h341, 32'd0);
    rd("post_rst_mcause", 12'h342, 32'd0);
    rd("post_rst_scr3", 12'h7C3, 32'd0);
    rd("post_rst_minstret", 12'hB02, 32'd0);
    rd("post_rst_minstreth", 12'hB82, 32'd0);

    tick();
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_data", o_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
